// File: rtl/shift_arbiter.sv
// Round-robin arbiter that time-shares one rotate-left barrel shifter among N_REQ
// valid/ready requesters and returns each result through a one-deep registered buffer.

module barrel_shifter #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SW    = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] in,
  input  logic [SW-1:0]    shift,
  output logic [WIDTH-1:0] out
);

  // Log-depth rotate: stage j rotates by 2^j when shift bit j is set.
  always_comb begin
    logic [WIDTH-1:0] tmp;
    tmp = in;
    for (int j = 0; j < int'(SW); j++) begin
      if (shift[j]) begin
        tmp = (tmp << (1 << j)) | (tmp >> (int'(WIDTH) - (1 << j)));
      end
    end
    out = tmp;
  end

endmodule

module shift_arbiter #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned N_REQ = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_REQ-1:0]            req_valid,
  output logic [N_REQ-1:0]            req_ready,
  input  logic [N_REQ*WIDTH-1:0]      req_data,
  input  logic [N_REQ*$clog2(WIDTH)-1:0] req_shift,
  output logic                        resp_valid,
  input  logic                        resp_ready,
  output logic [WIDTH-1:0]            resp_data,
  output logic [$clog2(N_REQ)-1:0]    resp_id,
  output logic [15:0]                 txn_count
);

  localparam int unsigned SW = $clog2(WIDTH);
  localparam int unsigned IW = $clog2(N_REQ);
  localparam int unsigned CW = 16;

  logic [IW-1:0]    ptr;
  logic [IW-1:0]    grant_idx;
  logic             grant_found;
  logic [WIDTH-1:0] sel_data;
  logic [SW-1:0]    sel_shift;
  logic [WIDTH-1:0] shift_out;
  logic [IW-1:0]    ptr_next;
  logic             stall;
  logic             accept;

  // First valid requester at or above ptr, wrapping; operand mux follows the grant.
  always_comb begin
    int unsigned idx;
    idx         = 0;
    grant_found = 1'b0;
    grant_idx   = '0;
    sel_data    = '0;
    sel_shift   = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      idx = (32'(ptr) + k) % N_REQ;
      if (!grant_found && req_valid[idx]) begin
        grant_found = 1'b1;
        grant_idx   = IW'(idx);
        sel_data    = req_data[idx*WIDTH +: WIDTH];
        sel_shift   = req_shift[idx*SW +: SW];
      end
    end
  end

  barrel_shifter #(
    .WIDTH (WIDTH),
    .SW    (SW)
  ) u_shifter (
    .in    (sel_data),
    .shift (sel_shift),
    .out   (shift_out)
  );

  assign stall    = resp_valid && !resp_ready;
  // Reset gates the handshake so nothing is accepted while state is being cleared.
  assign accept   = grant_found && !stall && rst_n;
  assign ptr_next = (grant_idx == IW'(N_REQ - 1)) ? '0 : grant_idx + IW'(1);

  always_comb begin
    req_ready = '0;
    if (accept) begin
      req_ready = N_REQ'(1) << grant_idx;
    end
  end

  // Response buffer, round-robin pointer and accept counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_id    <= '0;
      ptr        <= '0;
      txn_count  <= '0;
    end else if (accept) begin
      resp_valid <= 1'b1;
      resp_data  <= shift_out;
      resp_id    <= grant_idx;
      ptr        <= ptr_next;
      txn_count  <= txn_count + CW'(1);
    end else if (resp_valid && resp_ready) begin
      resp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed bench for shift_arbiter: a scoreboard queue holds predicted responses,
// pushed on predicted accepts and compared while the DUT buffer holds them.

module tb_shift_arbiter;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned N_REQ = 4;
  localparam int unsigned SW    = 3;
  localparam int unsigned IW    = 2;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ-1:0]       req_ready;
  logic [N_REQ*WIDTH-1:0] req_data;
  logic [N_REQ*SW-1:0]    req_shift;
  logic                   resp_valid;
  logic                   resp_ready;
  logic [WIDTH-1:0]       resp_data;
  logic [IW-1:0]          resp_id;
  logic [15:0]            txn_count;

  typedef struct {
    int               id;
    logic [WIDTH-1:0] data;
  } exp_t;

  exp_t        sb[$];
  int          tests = 0;
  int          fails = 0;
  int          mptr = 0;
  logic [15:0] mcount = '0;
  int          last_grant = -1;

  always #5 clk = ~clk;

  shift_arbiter #(
    .WIDTH (WIDTH),
    .N_REQ (N_REQ)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_data   (req_data),
    .req_shift  (req_shift),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_id    (resp_id),
    .txn_count  (txn_count)
  );

  function automatic logic [WIDTH-1:0] rotl(input logic [WIDTH-1:0] d, input int s);
    logic [2*WIDTH-1:0] t;
    t = {d, d} << s;
    return t[2*WIDTH-1:WIDTH];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: compare the held response and req_ready against the model, then advance.
  task automatic step();
    logic             stall;
    int               g;
    logic [N_REQ-1:0] exp_ready;
    exp_t             e;
    #1;
    if (!rst_n) begin
      check("reset_req_ready", 32'(req_ready), 32'(0));
      @(posedge clk);
      #1;
      sb.delete();
      mptr       = 0;
      mcount     = '0;
      last_grant = -1;
      check("reset_resp_valid", 32'(resp_valid), 32'(0));
      check("reset_resp_data", 32'(resp_data), 32'(0));
      check("reset_resp_id", 32'(resp_id), 32'(0));
      check("reset_txn_count", 32'(txn_count), 32'(0));
      return;
    end
    stall = (sb.size() != 0) && !resp_ready;
    check("resp_valid", 32'(resp_valid), 32'(sb.size() != 0));
    if (sb.size() != 0) begin
      check("resp_id", 32'(resp_id), 32'(sb[0].id));
      check("resp_data", 32'(resp_data), 32'(sb[0].data));
      if (resp_ready) void'(sb.pop_front());
    end
    g = -1;
    if (!stall) begin
      for (int k = 0; k < int'(N_REQ); k++) begin
        if (g < 0 && req_valid[(mptr + k) % N_REQ]) g = (mptr + k) % N_REQ;
      end
    end
    exp_ready = (g >= 0) ? N_REQ'(1 << g) : '0;
    check("req_ready", 32'(req_ready), 32'(exp_ready));
    last_grant = g;
    if (g >= 0) begin
      e.id   = g;
      e.data = rotl(req_data[g*WIDTH +: WIDTH], int'(req_shift[g*SW +: SW]));
      sb.push_back(e);
      mptr   = (g + 1) % N_REQ;
      mcount = mcount + 16'(1);
    end
    @(posedge clk);
    #1;
    check("txn_count", 32'(txn_count), 32'(mcount));
  endtask

  initial begin
    logic [WIDTH-1:0] rot_tab [8];
    int               seq13 [4];
    logic [15:0]      start_cnt;
    rot_tab = '{8'h56, 8'hAC, 8'h59, 8'hB2, 8'h65, 8'hCA, 8'h95, 8'h2B};
    seq13   = '{1, 3, 1, 3};

    // Reset held two cycles with every requester valid
    rst_n      = 1'b0;
    req_valid  = '1;
    resp_ready = 1'b1;
    for (int i = 0; i < int'(N_REQ); i++) begin
      req_data[i*WIDTH +: WIDTH] = WIDTH'(8'h11 * (i + 1));
      req_shift[i*SW +: SW]      = SW'(i);
    end
    step();
    step();

    // Single request from requester 2, then every rotation amount
    rst_n                      = 1'b1;
    req_valid                  = 4'b0100;
    req_data[2*WIDTH +: WIDTH] = 8'b0101_0110;
    req_shift[2*SW +: SW]      = 3'd3;
    step();
    check("single_valid", 32'(resp_valid), 32'(1));
    check("single_data", 32'(resp_data), 32'(8'b1011_0010));
    check("single_id", 32'(resp_id), 32'(2));
    check("single_count", 32'(txn_count), 32'(1));
    for (int s = 0; s < 8; s++) begin
      req_shift[2*SW +: SW] = SW'(s);
      step();
      check("sweep_data", 32'(resp_data), 32'(rot_tab[s]));
    end
    req_valid = '0;
    step();

    // Fairness with all requesters from reset, then with 1 and 3 only
    rst_n = 1'b0;
    step();
    rst_n     = 1'b1;
    req_valid = '1;
    for (int i = 0; i < int'(N_REQ); i++) begin
      req_data[i*WIDTH +: WIDTH] = WIDTH'(8'h81 + 8'h13 * i);
      req_shift[i*SW +: SW]      = SW'(i + 1);
    end
    for (int i = 0; i < 8; i++) begin
      step();
      check("fair_grant", 32'(last_grant), 32'(i % 4));
      check("fair_id", 32'(resp_id), 32'(i % 4));
    end
    req_valid = '0;
    step();
    req_valid = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      step();
      check("fair13_id", 32'(resp_id), 32'(seq13[i]));
    end
    req_valid = '0;
    step();

    // Backpressure: three stalled cycles, then consume-and-refill
    start_cnt = txn_count;
    req_valid = '1;
    step();
    resp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp_stall_ready", 32'(req_ready), 32'(0));
    end
    resp_ready = 1'b1;
    for (int i = 0; i < 3; i++) step();
    req_valid = '0;
    step();
    check("bp_drained_valid", 32'(resp_valid), 32'(0));
    check("bp_drained_sb", 32'(sb.size()), 32'(0));
    check("bp_count", 32'(txn_count), 32'(start_cnt + 16'd4));

    // Reset while a stalled response is held and ptr is 2
    rst_n = 1'b0;
    step();
    rst_n     = 1'b1;
    req_valid = 4'b0010;
    step();
    check("mid_first_grant", 32'(last_grant), 32'(1));
    req_valid  = '1;
    resp_ready = 1'b0;
    step();
    check("mid_held_valid", 32'(resp_valid), 32'(1));
    rst_n = 1'b0;
    step();
    rst_n      = 1'b1;
    resp_ready = 1'b1;
    step();
    check("mid_after_grant", 32'(last_grant), 32'(0));
    check("mid_after_id", 32'(resp_id), 32'(0));
    req_valid = '0;
    step();

    // Counter wrap after 65537 back-to-back accepts
    rst_n = 1'b0;
    step();
    rst_n      = 1'b1;
    resp_ready = 1'b1;
    req_valid  = 4'b0001;
    repeat (65537) @(posedge clk);
    #1;
    req_valid = '0;
    check("wrap_count", 32'(txn_count), 32'(1));
    check("wrap_valid", 32'(resp_valid), 32'(1));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/shift_arbiter.md
# shift_arbiter

Round-robin arbiter and sequencer that shares one instance of the team's `barrel_shifter` among `N_REQ` requesters over valid/ready handshakes. It selects one pending request per cycle and drives the shifter with that request's operand and amount. The result is captured in a one-deep registered response buffer tagged with the requester ID. It sits between the shift-issuing units and the shared shifter datapath.

## Interface
- `WIDTH`, 8: operand/result width; power of two, >= 2.
- `N_REQ`, 4: number of requesters; >= 2.
- Derived widths: `SW = $clog2(WIDTH)` (shift amount) and `IW = $clog2(N_REQ)` (requester ID).

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `req_valid`  in  N_REQ  bit i high means requester i has a pending request.
- `req_ready`  out  N_REQ  bit i high means requester i is accepted this cycle; at most one bit high.
- `req_data`  in  N_REQ*WIDTH  operand of requester i in bits [i*WIDTH +: WIDTH].
- `req_shift`  in  N_REQ*SW  shift amount of requester i in bits [i*SW +: SW].
- `resp_valid`  out  1  a response is held in the output buffer.
- `resp_ready`  in  1  the consumer accepts the response this cycle.
- `resp_data`  out  WIDTH  shifter result.
- `resp_id`  out  IW  index of the requester that produced `resp_data`.
- `txn_count`  out  16  number of accepted requests; wraps modulo 2^16.

## Operation
- One `barrel_shifter` instance. It is combinational: `out` = `in` rotated left by `shift`.
- Its inputs are muxed from the granted requester's `req_data` / `req_shift` slice.
- **Round-robin pointer `ptr` (IW bits).**
  - The grant goes to the first asserted `req_valid` bit, searching upward from `ptr` and wrapping past N_REQ-1 to 0.
  - No valid bits means no grant.
- **Output stall.** `stall = resp_valid && !resp_ready`.
  - `req_ready` = one-hot grant when `!stall`; all zeros when `stall`.
  - `req_ready` depends combinationally on `req_valid`, `resp_valid`, `resp_ready` and `ptr`.
- **Accept.** An accept of requester g occurs when `req_valid[g] && req_ready[g]`. At the next edge:
  - `resp_data` <= shifter output;
  - `resp_id` <= g;
  - `resp_valid` <= 1;
  - `ptr` <= (g+1) mod N_REQ;
  - `txn_count` <= `txn_count` + 1.
- **Consume without refill.** If `resp_valid && resp_ready` and there is no accept, `resp_valid` <= 0. `resp_data` and `resp_id` hold their last values.
- **Consume and refill in the same cycle.** The buffer is overwritten with the new result and `resp_valid` stays 1.
- **No accept.** `ptr` and `txn_count` are unchanged.
- **Stalled buffer.** While `stall`, `resp_data` and `resp_id` are stable.
- **Requester obligations.** A requester holds `req_valid`, `req_data` and `req_shift` stable until accepted.
  - Dropping `req_valid` before acceptance is legal.
  - No grant is remembered across cycles.
- A shift amount of 0 returns the operand unchanged.
- Shift amounts are SW bits wide, so they are always < WIDTH; there is no out-of-range case.
- **Starvation bound.** A continuously valid requester is accepted within N_REQ accepts.

## Timing
- **Reset.** When `rst_n` = 0 at an edge, all state is forced, overriding any accept or consume in that cycle:
  - `resp_valid`=0, `resp_data`=0, `resp_id`=0, `ptr`=0, `txn_count`=0.
- **Reset outputs.** During reset `req_ready` = 0.
- **Reset mid-operation.** A pending response is discarded; nothing is replayed.
- **Latency.** Accept at edge k; `resp_valid` and the result are visible in cycle k+1.
- **Throughput.** One request per cycle while `resp_ready` stays high.
- Simultaneous requests from all N_REQ requesters each complete once per N_REQ cycles, in rotating order.
- `txn_count` wraps from 16'hFFFF to 16'h0000 on the next accept.

## Test plan
- **Reset.**
  - Stimulus: hold `rst_n`=0 for 2 cycles with all `req_valid`=1.
  - Required: `req_ready`=0, `resp_valid`=0, `resp_data`=0, `resp_id`=0, `txn_count`=0 throughout.
- **Single request.**
  - Stimulus: `resp_ready`=1; requester 2 only, data 8'b0101_0110, shift 3.
  - Required: next cycle `resp_valid`=1, `resp_data`=8'b1011_0010, `resp_id`=2, `txn_count`=1.
  - Then sweep shift 0..7 and check every rotation; shift 0 must return 8'b0101_0110.
- **Fairness.**
  - Stimulus: all 4 requesters valid continuously, `resp_ready`=1, starting from reset.
  - Required: `resp_id` sequence 0,1,2,3,0,1,… with one response per cycle.
  - Repeat with only requesters 1 and 3 valid; required sequence 1,3,1,3.
- **Backpressure.**
  - Stimulus: `resp_ready`=0 for 3 cycles while requests are pending.
  - Required: `req_ready`=0 and `resp_data`/`resp_id` stable during the stall.
  - Then raise `resp_ready`; required: consume and refill in the same cycle, no response lost or duplicated, `txn_count` matching the number of accepts.
- **Mid-operation reset.**
  - Stimulus: assert `rst_n`=0 while `resp_valid`=1 and stalled, with `ptr`=2.
  - Required: after the reset edge, `resp_valid`=0 and `ptr`=0; the first grant goes to requester 0 when all are valid.
- **Counter wrap.**
  - Stimulus: 65 537 accepts.
  - Required: `txn_count`=1.
